pattern_serializer_101101: RTL and testbench
============================================

Name: pattern_serializer_101101

Overview:
- Serial pattern transmitter that drives the X input of the Lab Project 2 101101 sequence detectors.
- On a start request, emits a PAT_LEN-bit pattern MSB-first, one bit per clock, for a programmable number of frames. Frames are separated by GAP idle-zero cycles.
- Error injection corrupts the LSB of every frame so the detector's miss case can be exercised.
- Sits on the board between the switch/button debounce logic and the detector. Its bit stream also feeds the seven-segment status path.

Parameters:
- PAT_LEN, 6, pattern length in bits (2..8).
- PATTERN, 6'b101101, transmitted pattern, MSB sent first.
- GAP, 2, idle cycles (X=0, valid=0) inserted after every frame (0..7; 0 means frames are back-to-back).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- count  in  4  frames per burst, latched at start; 0 = continuous until stop.
- stop  in  1  request to end a continuous burst at the next frame boundary; sticky until honoured.
- err_inject  in  1  latched at start; when 1, the LSB of every frame is inverted.
- X  out  1  serial data bit to the detector.
- valid  out  1  1 while X carries a pattern bit.
- busy  out  1  1 from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of burst.
- bit_idx  out  3  index of the bit currently on X (PAT_LEN-1 down to 0); 0 when not valid.
- frames_sent  out  4  completed frames in the current or last burst; wraps 15 to 0.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; X=0, valid=0, busy=0, done=0, bit_idx=0, frames_sent=0. Latched count, stop and err_inject are cleared.
- Reset mid-burst aborts immediately; no partial frame continues and done is not pulsed.
- FSM states are IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 latches count, err_inject and a shift register loaded with PATTERN.
  - It also clears frames_sent and moves to SHIFT.
- SHIFT:
  - First SHIFT cycle is the cycle after the start edge (latency 1).
  - Drives valid=1, X=current MSB of the shift register and bit_idx=PAT_LEN-1..0 over PAT_LEN consecutive cycles.
  - On the bit_idx=0 cycle, X = PATTERN[0] XOR err_inject_latched.
  - After the last bit, frames_sent increments.
  - If the burst is complete, go to DONE. Otherwise go to GAP, or reload and stay in SHIFT when GAP=0.
- GAP:
  - Holds X=0, valid=0 for exactly GAP cycles.
  - Then reloads the shift register and returns to SHIFT.
- Burst complete:
  - count!=0: frames_sent (after increment) equals the latched count.
  - count=0: stop has been seen since start (sticky flag), evaluated at the end of each frame.
  - stop never truncates a frame. stop while IDLE is ignored.
- DONE: done=1, busy=0, valid=0, X=0 for one cycle, then IDLE. start is ignored during DONE.
- start while busy is ignored.
- busy=1 in SHIFT and GAP.
- frames_sent holds its value in IDLE until the next accepted start.
- Continuous mode past 15 frames wraps frames_sent to 0 without affecting operation.
- All outputs are registered except X, valid and bit_idx. Those are decoded combinationally from state and the shift register only (Moore-style, no input-to-output paths).

Test Plan:
- Reset low 2 cycles, release; start=1 for 1 cycle with count=1 -> valid high 6 cycles, X=1,0,1,1,0,1, bit_idx=5..0. Then done pulses 1 cycle; frames_sent=1, busy=0.
- count=3, GAP=2 -> stream 101101 00 101101 00 101101, then done; valid low during the gap cycles; frames_sent=3.
- count=2, err_inject=1 -> each frame is 101100; a connected detector reports Z=0 throughout.
- count=0, stop asserted mid-way through frame 2 -> frame 2 completes fully, then done; frames_sent=2, no frame 3.
- reset=0 on the 3rd bit of a frame -> next cycle X=0, valid=0, busy=0, frames_sent=0, no done pulse. A start pulse during busy in a separate run is ignored, with no change to frames_sent or timing.
- Cross-check against the Moore/Mealy detector, GAP=0, count=2 -> stream 101101101101. The detector flags the 6th bit with Mealy (M=1) timing, and one cycle later with Moore (M=0) timing.

Source files
------------

// File: rtl/pattern_serializer_101101.sv
// Serial pattern transmitter feeding the 101101 sequence detectors.
// Bursts of PAT_LEN-bit frames, MSB first, separated by GAP idle-zero cycles.
// X/valid/bit_idx are decoded from state; busy/done/frames_sent are registered.
module pattern_serializer_101101 #(
  parameter int                 PAT_LEN = 6,
  parameter logic [PAT_LEN-1:0] PATTERN = 6'b101101,
  parameter int                 GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       stop,
  input  logic       err_inject,
  output logic       X,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] bit_idx,
  output logic [3:0] frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(PAT_LEN - 1);
  // Gap counter counts down to zero, so it starts at GAP-1 (unused when GAP=0).
  localparam logic [2:0] GAP_LAST = (GAP == 0) ? 3'd0 : 3'(GAP - 1);

  state_t             state_q;
  logic [PAT_LEN-1:0] shreg_q;
  logic [2:0]         idx_q;
  logic [2:0]         gap_q;
  logic [3:0]         count_q;
  logic [3:0]         frames_q;
  logic               stop_q;
  logic               err_q;
  logic               busy_q;
  logic               done_q;

  logic [PAT_LEN-1:0] load_start_d;
  logic [PAT_LEN-1:0] load_d;
  logic [3:0]         frames_d;
  logic               last_bit;
  logic               complete;

  // Frame reload values (LSB optionally corrupted) and end-of-burst decision.
  always_comb begin
    load_start_d = PATTERN ^ {{(PAT_LEN-1){1'b0}}, err_inject};
    load_d       = PATTERN ^ {{(PAT_LEN-1){1'b0}}, err_q};
    frames_d     = frames_q + 4'd1;
    last_bit     = (idx_q == 3'd0);
    // A stop arriving on the last bit still counts: the frame is complete either way.
    complete     = (count_q != 4'd0) ? (frames_d == count_q) : (stop_q | stop);
  end

  // Burst sequencer: IDLE -> SHIFT (-> GAP -> SHIFT)* -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      idx_q    <= 3'd0;
      gap_q    <= 3'd0;
      count_q  <= 4'd0;
      frames_q <= 4'd0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            count_q  <= count;
            err_q    <= err_inject;
            shreg_q  <= load_start_d;
            idx_q    <= LAST_IDX;
            frames_q <= 4'd0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (stop) stop_q <= 1'b1;
          if (last_bit) begin
            frames_q <= frames_d;
            if (complete) begin
              stop_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (GAP == 0) begin
              shreg_q <= load_d;
              idx_q   <= LAST_IDX;
            end else begin
              gap_q   <= GAP_LAST;
              state_q <= S_GAP;
            end
          end else begin
            shreg_q <= shreg_q << 1;
            idx_q   <= idx_q - 3'd1;
          end
        end
        S_GAP: begin
          if (stop) stop_q <= 1'b1;
          if (gap_q == 3'd0) begin
            shreg_q <= load_d;
            idx_q   <= LAST_IDX;
            state_q <= S_SHIFT;
          end else begin
            gap_q <= gap_q - 3'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the serial outputs from state and shift register only.
  always_comb begin
    valid   = (state_q == S_SHIFT);
    X       = valid & shreg_q[PAT_LEN-1];
    bit_idx = valid ? idx_q : 3'd0;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_pattern_serializer_101101.sv
module tb_pattern_serializer_101101;

  localparam int          PAT_LEN = 6;
  localparam logic [5:0]  PAT     = 6'b101101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stop, err_inject;
  logic [3:0] count;
  logic       X_a, valid_a, busy_a, done_a;
  logic [2:0] bit_idx_a;
  logic [3:0] frames_sent_a;
  logic       X_b, valid_b, busy_b, done_b;
  logic [2:0] bit_idx_b;
  logic [3:0] frames_sent_b;

  pattern_serializer_101101 #(.PAT_LEN(6), .PATTERN(6'b101101), .GAP(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .count(count), .stop(stop),
    .err_inject(err_inject), .X(X_a), .valid(valid_a), .busy(busy_a),
    .done(done_a), .bit_idx(bit_idx_a), .frames_sent(frames_sent_a));

  pattern_serializer_101101 #(.PAT_LEN(6), .PATTERN(6'b101101), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .count(count), .stop(stop),
    .err_inject(err_inject), .X(X_b), .valid(valid_b), .busy(busy_b),
    .done(done_b), .bit_idx(bit_idx_b), .frames_sent(frames_sent_b));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: position p counts cycles since the burst began; a frame
  // slot is PAT_LEN + gap cycles long, the first PAT_LEN of which carry bits.
  int m_mode[2];   // 0 idle, 1 running, 2 done
  int m_p[2];
  int m_frames[2];
  int m_cnt[2];
  bit m_err[2], m_stop[2], m_busy[2], m_done[2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_step(input int i);
    int len, off;
    bit fin;
    len = PAT_LEN + gap_of(i);
    if (!reset) begin
      m_mode[i] = 0; m_p[i] = 0; m_frames[i] = 0; m_cnt[i] = 0;
      m_err[i] = 0; m_stop[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end else begin
      case (m_mode[i])
        0: begin
          m_done[i] = 0;
          if (start) begin
            m_mode[i] = 1; m_p[i] = 0; m_cnt[i] = int'(count);
            m_err[i] = err_inject; m_frames[i] = 0; m_stop[i] = 0; m_busy[i] = 1;
          end
        end
        1: begin
          if (stop) m_stop[i] = 1;
          off = m_p[i] % len;
          if (off == PAT_LEN - 1) begin
            m_frames[i] = (m_frames[i] + 1) % 16;
            fin = (m_cnt[i] != 0) ? (m_frames[i] == m_cnt[i]) : m_stop[i];
            if (fin) begin
              m_mode[i] = 2; m_busy[i] = 0; m_done[i] = 1;
            end else begin
              m_p[i] = m_p[i] + 1;
            end
          end else begin
            m_p[i] = m_p[i] + 1;
          end
        end
        default: begin
          m_done[i] = 0; m_mode[i] = 0;
        end
      endcase
    end
  endtask

  // Expected {X, valid, busy, done, bit_idx, frames_sent}.
  function automatic logic [10:0] model_out(input int i);
    logic [5:0] pat;
    int off, b;
    logic x, v;
    pat = PAT;
    off = m_p[i] % (PAT_LEN + gap_of(i));
    v = (m_mode[i] == 1) && (off < PAT_LEN);
    b = v ? (PAT_LEN - 1 - off) : 0;
    x = v ? (pat[b] ^ (m_err[i] && b == 0)) : 1'b0;
    return {x, v, m_busy[i], m_done[i], 3'(b), 4'(m_frames[i])};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [10:0] act, exp;
    for (int i = 0; i < 2; i++) begin
      act = (i == 0) ? {X_a, valid_a, busy_a, done_a, bit_idx_a, frames_sent_a}
                     : {X_b, valid_b, busy_b, done_b, bit_idx_b, frames_sent_b};
      exp = model_out(i);
      n_chk++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cycle dut%0d t=%0t: got %b expected %b", i, $time, act, exp);
      end
    end
  endtask

  // One clock: model sees the same inputs the DUTs sample, compare on negedge.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    if (chk_en) check_cycle();
  endtask

  task automatic run_burst(input logic [3:0] c, input logic e,
                           output int la, output int lb, output int ones);
    start = 1'b1; count = c; err_inject = e;
    tick();
    start = 1'b0;
    ones = int'(X_a & valid_a);
    la = -1; lb = -1;
    for (int n = 1; n <= 600 && (la < 0 || lb < 0); n++) begin
      tick();
      ones += int'(X_a & valid_a);
      if (done_a && la < 0) la = n;
      if (done_b && lb < 0) lb = n;
    end
  endtask

  task automatic wait_done(input string nm);
    bit sa, sb;
    sa = 0; sb = 0;
    for (int n = 0; n < 400 && !(sa && sb); n++) begin
      tick();
      if (done_a) sa = 1;
      if (done_b) sb = 1;
    end
    chk({nm, "_done_a"}, int'(sa), 1);
    chk({nm, "_done_b"}, int'(sb), 1);
  endtask

  typedef struct {
    logic [3:0] cnt;
    logic       err;
    int         frames;
    int         lat_a;   // cycles from start edge to done, GAP=2
    int         lat_b;   // same, GAP=0
    int         ones;    // ones carried on X of dut_a over the burst
  } vec_t;

  initial begin
    vec_t vecs[6];
    int la, lb, ones, dcnt;

    vecs[0] = '{4'd1,  1'b0, 1,   6,  6,  4};
    vecs[1] = '{4'd3,  1'b0, 3,  22, 18, 12};
    vecs[2] = '{4'd2,  1'b1, 2,  14, 12,  6};
    vecs[3] = '{4'd5,  1'b0, 5,  38, 30, 20};
    vecs[4] = '{4'd1,  1'b1, 1,   6,  6,  3};
    vecs[5] = '{4'd15, 1'b0, 15, 118, 90, 60};

    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_p[i] = 0; m_frames[i] = 0; m_cnt[i] = 0;
      m_err[i] = 0; m_stop[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end

    reset = 1'b0; start = 1'b0; stop = 1'b0; err_inject = 1'b0; count = 4'd0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_state_a", int'({X_a, valid_a, busy_a, done_a, bit_idx_a, frames_sent_a}), 0);
    chk("reset_state_b", int'({X_b, valid_b, busy_b, done_b, bit_idx_b, frames_sent_b}), 0);
    reset = 1'b1;
    tick();

    // Table of single bursts.
    foreach (vecs[k]) begin
      run_burst(vecs[k].cnt, vecs[k].err, la, lb, ones);
      chk($sformatf("v%0d_lat_a", k), la, vecs[k].lat_a);
      chk($sformatf("v%0d_lat_b", k), lb, vecs[k].lat_b);
      chk($sformatf("v%0d_ones", k), ones, vecs[k].ones);
      chk($sformatf("v%0d_frames_a", k), int'(frames_sent_a), vecs[k].frames);
      chk($sformatf("v%0d_frames_b", k), int'(frames_sent_b), vecs[k].frames);
      tick();
    end

    // Continuous mode, stop in the middle of the second frame.
    start = 1'b1; count = 4'd0; err_inject = 1'b0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("stop2");
    chk("stop2_frames_a", int'(frames_sent_a), 2);
    chk("stop2_frames_b", int'(frames_sent_b), 2);
    repeat (3) tick();
    chk("stop2_hold_a", int'(frames_sent_a), 2);

    // Continuous past 15 frames, frames_sent wraps.
    start = 1'b1; count = 4'd0;
    tick();
    start = 1'b0;
    repeat (140) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("wrap");
    chk("wrap_frames_a", int'(frames_sent_a), 2);
    chk("wrap_frames_b", int'(frames_sent_b), 8);
    tick();

    // Start while busy is ignored.
    start = 1'b1; count = 4'd2; err_inject = 1'b0;
    tick();
    start = 1'b0;
    la = -1;
    for (int n = 1; n <= 100 && la < 0; n++) begin
      if (n == 5) begin start = 1'b1; count = 4'd5; err_inject = 1'b1; end
      tick();
      start = 1'b0;
      if (done_a) la = n;
    end
    chk("busy_start_lat", la, 14);
    chk("busy_start_frames", int'(frames_sent_a), 2);
    tick();

    // Reset on the third bit of a frame aborts without done.
    start = 1'b1; count = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("bit3_idx", int'(bit_idx_a), 3);
    reset = 1'b0;
    tick();
    chk("abort_outs_a", int'({X_a, valid_a, busy_a, done_a, frames_sent_a}), 0);
    chk("abort_outs_b", int'({X_b, valid_b, busy_b, done_b, frames_sent_b}), 0);
    reset = 1'b1;
    dcnt = 0;
    repeat (10) begin
      tick();
      dcnt += int'(done_a) + int'(done_b) + int'(busy_a);
    end
    chk("abort_no_done", dcnt, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom_range(0, 99) != 0);
      start      = ($urandom_range(0, 7) == 0);
      count      = 4'($urandom_range(0, 4));
      err_inject = 1'($urandom_range(0, 1));
      stop       = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
